mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one external memory port between the instruction-cache and data-cache refill controllers of a core.
- Arbitrates at transaction granularity. Each granted transaction is sequenced through address handshake, data beats and completion, with a one-cycle done pulse back to the winning requester.
- Fixed data-side priority with a starvation guard, so instruction fetch always makes forward progress.

Parameters:
- ADDR_SIZE, 32, address width of every request and of the memory port.
- LEN_W, 8, burst length field width (AXI convention: beats = len+1).
- MAX_HOLD, 4, maximum consecutive data grants while instr_req is pending; the next grant then goes to instr. Legal range 1..15.

Ports:
- i_aclk  in  1  system clock
- i_areset_n  in  1  asynchronous reset, active low
- i_instr_req  in  1  instr cache requests a read burst; held until o_instr_done
- i_instr_addr  in  ADDR_SIZE  instr burst start address
- i_instr_len  in  LEN_W  instr burst length
- o_instr_gnt  out  1  instr owns the port (grant through done cycle)
- o_instr_done  out  1  one-cycle pulse, instr transaction complete
- i_data_req  in  1  data cache requests a burst; held until o_data_done
- i_data_we  in  1  1 = write burst, 0 = read burst
- i_data_addr  in  ADDR_SIZE  data burst start address
- i_data_len  in  LEN_W  data burst length
- o_data_gnt  out  1  data owns the port
- o_data_done  out  1  one-cycle pulse, data transaction complete
- o_mem_valid  out  1  address phase valid
- i_mem_ready  in  1  memory accepts the address phase
- o_mem_we  out  1  transaction direction
- o_mem_addr  out  ADDR_SIZE  registered address of the granted transaction
- o_mem_len  out  LEN_W  registered length of the granted transaction
- o_mem_id  out  1  owner: 0 = instr, 1 = data
- i_beat_valid  in  1  one data beat transferred (read or write) this cycle
- i_beat_last  in  1  qualifies i_beat_valid as the final beat
- i_wr_resp  in  1  write response handshake completed
- o_len_err  out  1  sticky: last beat arrived at a count different from len+1, or beat count exceeded len+1

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; hold counter 0; o_len_err 0.
- State IDLE:
  - Only data_req: grant data. Only instr_req: grant instr.
  - Both requesting: grant data unless the hold counter equals MAX_HOLD; in that case grant instr.
  - On grant, in the same edge: latch addr, len and we (we forced 0 for instr) into the o_mem_* registers; set gnt and id; go to ADDR.
  - Otherwise stay in IDLE.
- Hold counter:
  - Increments on each data grant made while instr_req is high, saturating at MAX_HOLD.
  - Clears on any instr grant, or on any IDLE cycle in which instr_req is low.
- State ADDR: o_mem_valid = 1. On i_mem_ready: clear beat counter; go to XFER. o_mem_valid must not drop before ready.
- State XFER:
  - Every i_beat_valid increments the 9-bit beat counter.
  - Read: i_beat_valid && i_beat_last ends the data phase; go to DONE.
  - Write: after the last beat, wait for i_wr_resp; then go to DONE. i_wr_resp in the same cycle as the last beat is also accepted.
  - If final count != len+1, or the counter passes len+1 before the last beat, set o_len_err. The transaction still completes normally.
- State DONE: the owner's done pulse is high for exactly one cycle; gnt is still high. Then go to IDLE with gnt cleared.
  - The requester drops req in the cycle after done. The earliest re-grant is the cycle after DONE (IDLE samples req). Minimum occupancy is 4 cycles.
- Ignored inputs:
  - Beats and i_wr_resp outside XFER.
  - i_wr_resp during a read.
  - Requester address changes after grant, since the values are registered.
- Reset mid-transaction: immediate return to IDLE; no done pulse; o_len_err cleared.
- At most one gnt high at any time. The done pulse only occurs with the matching gnt high.

Test Plan:
- Single instr read, addr=0x1000, len=3, ready after 2 cycles, 4 beats with last on 4th → o_mem_addr=0x1000, o_mem_id=0, o_instr_done single pulse after 4th beat, o_len_err=0.
- Simultaneous instr and data requests, both held continuously (MAX_HOLD=4) → grant order D,D,D,D,I, then the counter clears and data wins again.
- Data write, len=1, 2 beats, then i_wr_resp 3 cycles later → o_mem_we=1; o_data_done exactly 1 cycle after i_wr_resp; no done before the response.
- Read len=3 with i_beat_last on the 2nd beat → o_len_err=1 and stays 1 through later clean transactions; done still pulses.
- Assert reset in XFER of a data read → all outputs 0 next edge, no done; after release an instr_req is granted normally.
- Stray i_beat_valid and i_wr_resp while in IDLE, and i_wr_resp during a read XFER → no state change, no done, beat counter unaffected.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between the instr and data refill controllers.
// Transaction-granular arbitration: data wins unless instr has waited MAX_HOLD grants.
//
// state | meaning
// IDLE  | no owner; sample requests and grant
// ADDR  | address phase valid, waiting for i_mem_ready
// XFER  | counting data beats; writes also wait for i_wr_resp
// DONE  | one-cycle done pulse to the owner, grant still held
module mem_port_arbiter #(
  parameter int ADDR_SIZE = 32,
  parameter int LEN_W     = 8,
  parameter int MAX_HOLD  = 4
) (
  input  logic                 i_aclk,
  input  logic                 i_areset_n,
  input  logic                 i_instr_req,
  input  logic [ADDR_SIZE-1:0] i_instr_addr,
  input  logic [LEN_W-1:0]     i_instr_len,
  output logic                 o_instr_gnt,
  output logic                 o_instr_done,
  input  logic                 i_data_req,
  input  logic                 i_data_we,
  input  logic [ADDR_SIZE-1:0] i_data_addr,
  input  logic [LEN_W-1:0]     i_data_len,
  output logic                 o_data_gnt,
  output logic                 o_data_done,
  output logic                 o_mem_valid,
  input  logic                 i_mem_ready,
  output logic                 o_mem_we,
  output logic [ADDR_SIZE-1:0] o_mem_addr,
  output logic [LEN_W-1:0]     o_mem_len,
  output logic                 o_mem_id,
  input  logic                 i_beat_valid,
  input  logic                 i_beat_last,
  input  logic                 i_wr_resp,
  output logic                 o_len_err
);

  localparam int BEAT_W = LEN_W + 1;
  localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_XFER, S_DONE} state_t;

  state_t            state;
  logic [3:0]        hold_cnt;
  logic [BEAT_W-1:0] beat_cnt;
  logic              last_seen;

  logic              pick_instr;
  logic [BEAT_W-1:0] len_p1;
  logic [BEAT_W-1:0] beat_nxt;

  always_comb begin
    pick_instr = i_instr_req && (!i_data_req || hold_cnt == HOLD_MAX);
    len_p1     = {1'b0, o_mem_len} + BEAT_W'(1);
    beat_nxt   = beat_cnt + BEAT_W'(1);
  end

  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      state        <= S_IDLE;
      hold_cnt     <= '0;
      beat_cnt     <= '0;
      last_seen    <= 1'b0;
      o_instr_gnt  <= 1'b0;
      o_instr_done <= 1'b0;
      o_data_gnt   <= 1'b0;
      o_data_done  <= 1'b0;
      o_mem_valid  <= 1'b0;
      o_mem_we     <= 1'b0;
      o_mem_addr   <= '0;
      o_mem_len    <= '0;
      o_mem_id     <= 1'b0;
      o_len_err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!i_instr_req) hold_cnt <= '0;
          if (pick_instr) begin
            o_instr_gnt <= 1'b1;
            o_mem_id    <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= i_instr_addr;
            o_mem_len   <= i_instr_len;
            o_mem_valid <= 1'b1;
            hold_cnt    <= '0;
            state       <= S_ADDR;
          end else if (i_data_req) begin
            o_data_gnt  <= 1'b1;
            o_mem_id    <= 1'b1;
            o_mem_we    <= i_data_we;
            o_mem_addr  <= i_data_addr;
            o_mem_len   <= i_data_len;
            o_mem_valid <= 1'b1;
            if (i_instr_req && hold_cnt < HOLD_MAX) hold_cnt <= hold_cnt + 4'd1;
            state       <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (i_mem_ready) begin
            o_mem_valid <= 1'b0;
            beat_cnt    <= '0;
            last_seen   <= 1'b0;
            state       <= S_XFER;
          end
        end
        S_XFER: begin
          if (i_beat_valid && !last_seen) begin
            beat_cnt <= beat_nxt;
            if (i_beat_last) begin
              if (beat_nxt != len_p1) o_len_err <= 1'b1;
              // a write response coinciding with the last beat closes the write at once
              if (!o_mem_we || i_wr_resp) begin
                o_instr_done <= !o_mem_id;
                o_data_done  <= o_mem_id;
                state        <= S_DONE;
              end else begin
                last_seen <= 1'b1;
              end
            end else if (beat_nxt > len_p1) begin
              o_len_err <= 1'b1;
            end
          end else if (last_seen && i_wr_resp) begin
            o_instr_done <= !o_mem_id;
            o_data_done  <= o_mem_id;
            state        <= S_DONE;
          end
        end
        S_DONE: begin
          o_instr_done <= 1'b0;
          o_data_done  <= 1'b0;
          o_instr_gnt  <= 1'b0;
          o_data_gnt   <= 1'b0;
          state        <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
